ahb_mem_slave: RTL and testbench

//  AHB-2 responder: word-organised SRAM model on the slave side of the generic arbiter.
//  - Receives s_hsel/s_addr_out/s_htrans_out/s_hwrite/s_hsize/s_data_out.
//  - Returns hready_out/hresp/hrdata into the s_hready/s_hresp/s_hrdata slices.
//  - Programmable wait states, byte/halfword/word lanes, two-cycle ERROR response.

---
 rtl/ahb_mem_slave.sv | 176 +++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-2 word-organised SRAM responder with programmable wait states and byte lanes.
// Define AHB_SLV_ERR_EN to answer illegal beats with the two-cycle ERROR response.
module ahb_mem_slave #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic        hready_in,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           r_state, w_next, w_entry;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_mask;
  logic             r_write, r_err;
  logic             r_hready, w_hready;
  logic [1:0]       r_hresp, w_hresp;
  logic [31:0]      r_hrdata, w_hrdata;
  logic [31:0]      r_mem [MEM_DEPTH];

  logic [31:0]      w_offset;
  logic             w_in_range, w_misalign, w_err, w_addr_phase, w_accept, w_commit;
  logic [IDX_W-1:0] w_idx, w_rd_idx;
  logic [3:0]       w_mask;
  logic             w_rd_write, w_rd_err;
  logic [31:0]      w_rd_word, w_rd_data;
  logic             w_unused;

  // address-phase decode of the live bus
  assign w_offset     = haddr - ADDR_BASE;
  assign w_in_range   = (haddr >= ADDR_BASE) && ({2'b00, w_offset[31:2]} < 32'(MEM_DEPTH));
  assign w_misalign   = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err        = !w_in_range || w_misalign || (hsize > 3'd2);
  assign w_idx        = w_offset[IDX_W+1:2];
  assign w_addr_phase = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept     = w_addr_phase && hsel && hready_in && htrans[1];
  assign w_unused     = ^{hburst, w_offset[1:0]};

  always_comb begin
    w_mask = 4'b0000;
    case (hsize)
      3'd0:    w_mask = 4'b0001 << haddr[1:0];
      3'd1:    w_mask = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  always_comb begin
    w_entry = S_DATA;
    if (HAS_WAIT)              w_entry = S_WAIT;
    else if (ERR_EN && w_err)  w_entry = S_ERR1;
  end

  // write commits on the edge that closes DATA; a reset on that edge drops it
  assign w_commit = (r_state == S_DATA) && r_write && !r_err && !hreset;

  // read source: held beat when leaving WAIT, live beat on a zero-wait entry
  assign w_rd_idx   = (r_state == S_WAIT) ? r_idx   : w_idx;
  assign w_rd_write = (r_state == S_WAIT) ? r_write : hwrite;
  assign w_rd_err   = (r_state == S_WAIT) ? r_err   : w_err;

  // write-first forwarding for a read entering DATA on the same edge as a commit
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_commit && (r_idx == w_rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
    w_rd_data = (w_rd_write || w_rd_err) ? 32'h0 : w_rd_word;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_hready   <= 1'b1;
      r_hresp    <= RESP_OKAY;
      r_hrdata   <= 32'h0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt;
      r_hready   <= w_hready;
      r_hresp    <= w_hresp;
      r_hrdata   <= w_hrdata;
    end
  end

  // next state, with registered outputs decoded from the state being entered
  always_comb begin
    w_next     = r_state;
    w_wait_cnt = r_wait_cnt;
    w_hready   = 1'b1;
    w_hresp    = RESP_OKAY;
    w_hrdata   = 32'h0;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        w_next = S_IDLE;
        if (w_accept) begin
          w_next     = w_entry;
          w_wait_cnt = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) w_next = (ERR_EN && r_err) ? S_ERR1 : S_DATA;
        else                  w_wait_cnt = r_wait_cnt - CNT_W'(1);
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
    case (w_next)
      S_WAIT: w_hready = 1'b0;
      S_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = RESP_ERROR;
      end
      S_ERR2: w_hresp  = RESP_ERROR;
      S_DATA: w_hrdata = w_rd_data;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_idx   <= '0;
      r_mask  <= 4'b0000;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_idx;
      r_mask  <= w_mask;
      r_write <= hwrite;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hready_out = r_hready;
  assign hresp      = r_hresp;
  assign hrdata     = r_hrdata;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: random AHB beats on two slaves (0 and 2 wait states) checked against a byte-lane memory model.
module tb_ahb_mem_slave;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int NDUT = 2;
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel_a      [NDUT];
  logic [31:0] haddr_a     [NDUT];
  logic [1:0]  htrans_a    [NDUT];
  logic        hwrite_a    [NDUT];
  logic [2:0]  hsize_a     [NDUT];
  logic [2:0]  hburst_a    [NDUT];
  logic [31:0] hwdata_a    [NDUT];
  logic        hready_out_a[NDUT];
  logic [1:0]  hresp_a     [NDUT];
  logic [31:0] hrdata_a    [NDUT];

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] mdl [NDUT][DEPTH];
  logic [31:0] last_rd;
  logic [31:0] pre;
  beat_t       q[$];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_mem_slave #(
      .MEM_DEPTH  (DEPTH),
      .ADDR_BASE  (BASE),
      .WAIT_STATES(g * 2)
    ) u_dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel_a[g]),
      .hready_in (hready_out_a[g]),
      .haddr     (haddr_a[g]),
      .htrans    (htrans_a[g]),
      .hwrite    (hwrite_a[g]),
      .hsize     (hsize_a[g]),
      .hburst    (hburst_a[g]),
      .hwdata    (hwdata_a[g]),
      .hready_out(hready_out_a[g]),
      .hresp     (hresp_a[g]),
      .hrdata    (hrdata_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit is_err(input beat_t b);
    if (b.addr < BASE) return 1'b1;
    if (((b.addr - BASE) >> 2) >= 32'(DEPTH)) return 1'b1;
    if (b.size > 3'd2) return 1'b1;
    if ((b.size == 3'd1) && b.addr[0]) return 1'b1;
    if ((b.size == 3'd2) && (b.addr[1:0] != 2'b00)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int idx_of(input beat_t b);
    return int'((b.addr - BASE) >> 2);
  endfunction

  // data-phase cycle on which the beat completes
  function automatic int fin_of(input int d, input beat_t b);
    return (ERR_EN && is_err(b)) ? ws(d) + 1 : ws(d);
  endfunction

  function automatic void apply_write(input int d, input beat_t b);
    int i;
    i = idx_of(b);
    for (int k = 0; k < 4; k++) begin
      bit en;
      case (b.size)
        3'd0:    en = (k == int'(b.addr[1:0]));
        3'd1:    en = ((k / 2) == int'(b.addr[1]));
        default: en = 1'b1;
      endcase
      if (en) mdl[d][i][8*k +: 8] = b.wdata[8*k +: 8];
    end
  endfunction

  task automatic drive_addr(input int d, input beat_t b);
    hsel_a[d]   = b.sel;
    htrans_a[d] = b.trans;
    haddr_a[d]  = b.addr;
    hwrite_a[d] = b.wr;
    hsize_a[d]  = b.size;
    hburst_a[d] = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_idle(input int d);
    hsel_a[d]   = 1'b0;
    htrans_a[d] = 2'b00;
    haddr_a[d]  = $urandom;
    hwrite_a[d] = 1'($urandom_range(0, 1));
    hsize_a[d]  = 3'd0;
    hburst_a[d] = 3'd0;
  endtask

  task automatic push(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                      input bit wr, input logic [2:0] sz, input logic [31:0] wd);
    beat_t b;
    b.sel = sel; b.trans = tr; b.addr = a; b.wr = wr; b.size = sz; b.wdata = wd;
    q.push_back(b);
  endtask

  // pipelined master: presents queued beats, checks every cycle of every data phase
  task automatic run_seq(input int d);
    beat_t ab, db;
    bit av, dv, hr, chk_data;
    int k, dc, cyc, limit;
    logic e_rdy;
    logic [1:0] e_resp;
    logic [31:0] e_data;
    k = 0; av = 1'b0; dv = 1'b0; dc = 0; cyc = 0; ab = '0; db = '0;
    limit = 20 * q.size() + 20;
    if (q.size() > 0) begin
      ab = q[0]; k = 1; av = 1'b1; drive_addr(d, ab);
    end else drive_idle(d);
    hwdata_a[d] = $urandom;
    while ((av || dv) && (cyc < limit)) begin
      cyc++;
      @(negedge hclk);
      hr = hready_out_a[d];
      e_rdy = 1'b1; e_resp = 2'b00; e_data = 32'h0; chk_data = 1'b1;
      if (dv) begin
        e_rdy = (dc >= fin_of(d, db));
        if (ERR_EN && is_err(db)) begin
          e_resp = (dc >= ws(d)) ? 2'b01 : 2'b00;
        end else if (dc >= fin_of(d, db)) begin
          if (db.wr) chk_data = 1'b0;
          else if (!is_err(db)) e_data = mdl[d][idx_of(db)];
        end
      end
      chk($sformatf("d%0d hready_out @%h", d, db.addr), 32'(hr), 32'(e_rdy));
      chk($sformatf("d%0d hresp @%h", d, db.addr), 32'(hresp_a[d]), 32'(e_resp));
      if (chk_data) chk($sformatf("d%0d hrdata @%h", d, db.addr), hrdata_a[d], e_data);
      if (dv && (dc == fin_of(d, db))) begin
        if (db.wr && !is_err(db)) apply_write(d, db);
        if (!db.wr) last_rd = hrdata_a[d];
      end
      @(posedge hclk);
      #1;
      if (hr) begin
        dv = av && ab.sel && ab.trans[1];
        db = ab; dc = 0; av = 1'b0;
        if (k < q.size()) begin
          ab = q[k]; k++; av = 1'b1; drive_addr(d, ab);
        end else drive_idle(d);
      end else dc++;
      hwdata_a[d] = (dv && db.wr && (dc == fin_of(d, db))) ? db.wdata : $urandom;
    end
    if (av || dv) chk($sformatf("d%0d sequence timeout", d), 32'd1, 32'd0);
    q.delete();
  endtask

  task automatic gen_random(input int n);
    logic [31:0] prev = 32'h0;
    for (int i = 0; i < n; i++) begin
      int r;
      logic [31:0] a;
      logic [2:0] sz;
      bit sel;
      logic [1:0] tr;
      r   = $urandom_range(0, 99);
      sz  = 3'($urandom_range(0, 2));
      sel = 1'b1;
      tr  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
      a   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if (r < 20)      a  = prev;
      else if (r < 30) a  = BASE + 32'(4 * DEPTH) + (32'($urandom_range(0, 65535)) & 32'hFFFF_FFFC);
      else if (r < 38) sz = 3'($urandom_range(3, 7));
      else if (r < 46) tr = 2'($urandom_range(0, 1));
      else if (r < 52) sel = 1'b0;
      prev = a;
      push(sel, tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
    end
  endtask

  initial begin
    hreset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      drive_idle(d);
      hwdata_a[d] = 32'h0;
    end
    repeat (3) @(posedge hclk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d reset hready_out", d), 32'(hready_out_a[d]), 32'd1);
      chk($sformatf("d%0d reset hresp", d), 32'(hresp_a[d]), 32'd0);
      chk($sformatf("d%0d reset hrdata", d), hrdata_a[d], 32'h0);
    end
    hreset = 1'b0;

    // fill the working window so every later read has a known value
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 64; w++) push(1'b1, (w == 0) ? 2'b10 : 2'b11, 32'(4 * w), 1'b1, 3'd2, $urandom);
      run_seq(d);
    end

    // zero-wait write then read of the same word
    push(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    run_seq(0);
    chk("t1 read-after-write", last_rd, 32'hDEADBEEF);

    // two-wait read with the next NONSEQ held through the data phase
    push(1'b1, 2'b10, 32'h4, 1'b0, 3'd2, 32'h0);
    push(1'b1, 2'b10, 32'h8, 1'b0, 3'd2, 32'h0);
    run_seq(1);

    for (int d = 0; d < NDUT; d++) begin
      push(1'b1, 2'b10, 32'h20, 1'b1, 3'd0, 32'h0000_0011);
      push(1'b1, 2'b10, 32'h21, 1'b1, 3'd0, 32'h0000_2200);
      push(1'b1, 2'b10, 32'h22, 1'b1, 3'd1, 32'h4433_0000);
      push(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
      run_seq(d);
      chk($sformatf("d%0d t3 lane merge", d), last_rd, 32'h44332211);

      push(1'b1, 2'b10, BASE + 32'(4 * DEPTH), 1'b0, 3'd2, 32'h0);
      push(1'b1, 2'b00, 32'h20, 1'b0, 3'd2, 32'h0);
      push(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
      run_seq(d);

      pre = mdl[d][8];
      push(1'b1, 2'b10, 32'h22, 1'b1, 3'd2, 32'h5A5A_5A5A);
      push(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
      run_seq(d);
      chk($sformatf("d%0d t5 misaligned write dropped", d), last_rd, pre);
    end

    // reset in the wait state of a write abandons it
    pre = mdl[1][12];
    hsel_a[1] = 1'b1; htrans_a[1] = 2'b10; haddr_a[1] = 32'h30; hwrite_a[1] = 1'b1; hsize_a[1] = 3'd2;
    @(posedge hclk);
    #1;
    chk("t6 in wait", 32'(hready_out_a[1]), 32'd0);
    drive_idle(1);
    hwdata_a[1] = 32'hCAFE0000;
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    chk("t6 reset hready_out", 32'(hready_out_a[1]), 32'd1);
    chk("t6 reset hresp", 32'(hresp_a[1]), 32'd0);
    chk("t6 reset hrdata", hrdata_a[1], 32'h0);
    hreset = 1'b0;
    push(1'b1, 2'b10, 32'h30, 1'b0, 3'd2, 32'h0);
    run_seq(1);
    chk("t6 write dropped", last_rd, pre);

    for (int d = 0; d < NDUT; d++) begin
      gen_random(300);
      run_seq(d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
